// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the RV32I write-back stage.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/half/word from an aligned load word
// and flags misaligned accesses and illegal load encodings.
module load_align
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        data     = '0;
        err      = 1'b0;
        byte_sel = word[7:0];
        half_sel = off[1] ? word[31:16] : word[15:0];

        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase

        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(XLEN-16){half_sel[15]}}, half_sel};
                err  = off[0];
            end
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, half_sel};
                err  = off[0];
            end
            F3_LW: begin
                data = word;
                err  = (off != 2'd0);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions, waits for load data,
// and drives the register-file write port, retire pulse and instret.
module wb_stage
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic [RAW-1:0]  in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_data,
    output logic            RegWrite,
    output logic [RAW-1:0]  W_Adrs,
    output logic [XLEN-1:0] W_Data,
    output logic            retire,
    output logic            ld_err,
    output logic [31:0]     instret
);

    wb_state_e       state_q, state_d;
    logic [RAW-1:0]  rd_q;
    logic            reg_write_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [31:0]     instret_q;

    logic            accept, load_accept, alu_done, load_done;
    logic [XLEN-1:0] ld_aligned;
    logic            ld_bad;

    assign accept      = in_valid && in_ready;
    assign load_accept = accept && (in_wb_sel == WB_LOAD);
    assign alu_done    = accept && (in_wb_sel != WB_LOAD);
    assign load_done   = (state_q == WAIT_LOAD) && ld_valid;
    assign instret     = instret_q;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (load_accept) state_d = WAIT_LOAD;
            end
            WAIT_LOAD: if (ld_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: load context needs no reset; it is only read in WAIT_LOAD, entered right after it is loaded.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
            funct3_q    <= in_funct3;
            off_q       <= in_alu_result[1:0];
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3 (funct3_q),
        .off    (off_q),
        .word   (ld_data),
        .data   (ld_aligned),
        .err    (ld_bad)
    );

    // Write port is fully registered; pulses clear every cycle unless a completion lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            W_Adrs    <= '0;
            W_Data    <= '0;
            retire    <= 1'b0;
            ld_err    <= 1'b0;
            instret_q <= '0;
        end else begin
            RegWrite <= 1'b0;
            ld_err   <= 1'b0;
            retire   <= alu_done || load_done;
            if (alu_done) begin
                W_Adrs   <= in_rd;
                W_Data   <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_result;
                RegWrite <= in_reg_write && (in_rd != '0);
            end else if (load_done) begin
                W_Adrs   <= rd_q;
                W_Data   <= ld_aligned;
                RegWrite <= reg_write_q && (rd_q != '0) && !ld_bad;
                ld_err   <= ld_bad;
            end
            if (alu_done || load_done) instret_q <= instret_q + 32'd1;
        end
    end

endmodule
